// File: rtl/rfid_frame_parser.sv
// Assembles STX + 10 hex ID chars + 2 hex XOR-checksum chars + ETX from a UART byte strobe.
// Registered outputs, 1-cycle latency from the terminating byte; no backpressure, one byte per cycle accepted.
module rfid_frame_parser #(
    parameter int TIMEOUT_CYCLES = 156250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [39:0] tag_id,
    output logic        tag_valid,
    output logic        tag_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    // Expiry fires on the edge where the idle count would reach TIMEOUT_CYCLES-1.
    localparam logic [CW-1:0] TO_HIT = CW'(TIMEOUT_CYCLES - 2);

    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h03;

    typedef enum logic [1:0] {IDLE, DATA, CSUM, ETX_WAIT} state_t;

    state_t         state;
    logic [CW-1:0]  tmo_cnt;
    logic [3:0]     char_cnt;
    logic [39:0]    id_sr;
    logic [7:0]     run_xor;
    logic [7:0]     rx_csum;

    logic           hex_ok;
    logic [3:0]     hex_nib;
    logic           bad_byte;

    always_comb begin
        hex_ok  = 1'b1;
        hex_nib = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            hex_nib = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            hex_nib = rx_data[3:0] + 4'd9;
        end else begin
            hex_ok = 1'b0;
        end
    end

    always_comb begin
        bad_byte = 1'b0;
        if (state == DATA || state == CSUM) begin
            bad_byte = !hex_ok;
        end else if (state == ETX_WAIT) begin
            bad_byte = (rx_data != ETX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            char_cnt  <= 4'd0;
            id_sr     <= 40'd0;
            run_xor   <= 8'd0;
            rx_csum   <= 8'd0;
            tag_id    <= 40'd0;
            tag_valid <= 1'b0;
            tag_err   <= 1'b0;
            err_code  <= 2'd0;
            busy      <= 1'b0;
        end else begin
            tag_valid <= 1'b0;
            tag_err   <= 1'b0;
            if (rx_ready && rx_data == STX) begin
                // An STX mid-frame reports a resync but still opens the new frame.
                if (state != IDLE) begin
                    tag_err  <= 1'b1;
                    err_code <= 2'd3;
                end
                state    <= DATA;
                busy     <= 1'b1;
                char_cnt <= 4'd0;
                id_sr    <= 40'd0;
                run_xor  <= 8'd0;
                rx_csum  <= 8'd0;
                tmo_cnt  <= '0;
            end else if (state != IDLE) begin
                if (rx_ready) begin
                    tmo_cnt <= '0;
                    if (bad_byte) begin
                        tag_err  <= 1'b1;
                        err_code <= 2'd0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        case (state)
                            DATA: begin
                                id_sr <= {id_sr[35:0], hex_nib};
                                if (char_cnt[0]) begin
                                    run_xor <= run_xor ^ {id_sr[3:0], hex_nib};
                                end
                                if (char_cnt == 4'd9) begin
                                    char_cnt <= 4'd0;
                                    state    <= CSUM;
                                end else begin
                                    char_cnt <= char_cnt + 4'd1;
                                end
                            end
                            CSUM: begin
                                rx_csum <= {rx_csum[3:0], hex_nib};
                                if (char_cnt == 4'd1) begin
                                    char_cnt <= 4'd0;
                                    state    <= ETX_WAIT;
                                end else begin
                                    char_cnt <= char_cnt + 4'd1;
                                end
                            end
                            ETX_WAIT: begin
                                if (rx_csum == run_xor) begin
                                    tag_valid <= 1'b1;
                                    tag_id    <= id_sr;
                                end else begin
                                    tag_err  <= 1'b1;
                                    err_code <= 2'd1;
                                end
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                            default: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                end else if (tmo_cnt == TO_HIT) begin
                    tag_err  <= 1'b1;
                    err_code <= 2'd2;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end else begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rfid_frame_parser.sv
// Self-checking bench for rfid_frame_parser: vector table, directed corner cases, random frames vs a buffer-based model.
`timescale 1ns/1ps
module tb_rfid_frame_parser;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [39:0] tag_id;
    logic        tag_valid;
    logic        tag_err;
    logic [1:0]  err_code;
    logic        busy;

    always #5 clk = ~clk;

    rfid_frame_parser #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tag_id    (tag_id),
        .tag_valid (tag_valid),
        .tag_err   (tag_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: bytes collected since the last STX, judged by position.
    logic [7:0]  mbuf[$];
    bit          mact;
    logic [39:0] m_id;
    logic [1:0]  m_code;
    bit          m_v;
    bit          m_e;

    typedef struct {
        string       body;
        bit          v;
        bit          e;
        logic [1:0]  code;
        logic [39:0] id;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
    endfunction

    function automatic int hexval(input logic [7:0] c);
        if (c <= 8'h39) return int'(c) - 'h30;
        else if (c <= 8'h46) return int'(c) - 'h41 + 10;
        else return int'(c) - 'h61 + 10;
    endfunction

    function automatic logic [7:0] hexc(input logic [3:0] v, input bit lower);
        if (v < 4'd10) return 8'h30 + 8'(v);
        return (lower ? 8'h61 : 8'h41) + 8'(v) - 8'd10;
    endfunction

    task automatic model_step(input logic [7:0] b);
        logic [39:0] id;
        logic [7:0]  sum;
        logic [7:0]  rc;
        m_v = 1'b0;
        m_e = 1'b0;
        if (b == 8'h02) begin
            if (mact) begin m_e = 1'b1; m_code = 2'd3; end
            mact = 1'b1;
            mbuf.delete();
        end else if (mact) begin
            mbuf.push_back(b);
            if (mbuf.size() <= 12) begin
                if (!is_hex(b)) begin m_e = 1'b1; m_code = 2'd0; mact = 1'b0; end
            end else begin
                if (b != 8'h03) begin
                    m_e = 1'b1; m_code = 2'd0;
                end else begin
                    id  = 40'd0;
                    sum = 8'd0;
                    for (int i = 0; i < 10; i++) id = (id << 4) | 40'(hexval(mbuf[i]));
                    for (int k = 0; k < 5; k++)
                        sum ^= 8'(hexval(mbuf[2*k]) * 16 + hexval(mbuf[2*k+1]));
                    rc = 8'(hexval(mbuf[10]) * 16 + hexval(mbuf[11]));
                    if (sum == rc) begin m_v = 1'b1; m_id = id; end
                    else begin m_e = 1'b1; m_code = 2'd1; end
                end
                mact = 1'b0;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was sampled.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        model_step(b);
        @(negedge clk);
        rx_ready = 1'b0;
        chk("byte_valid", tag_valid, m_v);
        chk("byte_err",   tag_err,   m_e);
        chk("byte_code",  err_code,  m_code);
        chk("byte_id",    tag_id,    m_id);
        chk("byte_busy",  busy,      mact);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_strobe", {tag_valid, tag_err}, 2'b00);
            chk("idle_busy", busy, mact);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Expects expiry on the 99th edge after the last accepted byte.
    task automatic expect_timeout(input string nm);
        bit early = 1'b0;
        for (int k = 1; k < TO - 1; k++) begin
            @(negedge clk);
            if (tag_err || !busy) early = 1'b1;
        end
        chk({nm, "_early"}, early, 1'b0);
        @(negedge clk);
        chk({nm, "_err"},  tag_err,  1'b1);
        chk({nm, "_code"}, err_code, 2'd2);
        chk({nm, "_busy"}, busy,     1'b0);
        mact = 1'b0; m_code = 2'd2;
        @(negedge clk);
        chk({nm, "_pulse"}, tag_err, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"0A1B2C3D4E4E", 1'b1, 1'b0, 2'd0, 40'h0A1B2C3D4E};
        vecs[1] = '{"0a1b2c3d4e4e", 1'b1, 1'b0, 2'd0, 40'h0A1B2C3D4E};
        vecs[2] = '{"0A1B2C3D4E4F", 1'b0, 1'b1, 2'd1, 40'h0A1B2C3D4E};
        vecs[3] = '{"FFFFFFFFFFFF", 1'b1, 1'b0, 2'd0, 40'hFFFFFFFFFF};
        vecs[4] = '{"123456789A92", 1'b1, 1'b0, 2'd0, 40'h123456789A};
        vecs[5] = '{"000000000000", 1'b1, 1'b0, 2'd0, 40'h0000000000};

        mact = 1'b0; m_id = 40'd0; m_code = 2'd0; m_v = 1'b0; m_e = 1'b0;
        rst_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_id",    tag_id,    40'd0);
        chk("rst_valid", tag_valid, 1'b0);
        chk("rst_err",   tag_err,   1'b0);
        chk("rst_code",  err_code,  2'd0);
        chk("rst_busy",  busy,      1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            send_byte(8'h02);
            send_str(vecs[i].body);
            send_byte(8'h03);
            chk("vec_valid", tag_valid, vecs[i].v);
            chk("vec_err",   tag_err,   vecs[i].e);
            if (vecs[i].e) chk("vec_code", err_code, vecs[i].code);
            chk("vec_id",    tag_id,    vecs[i].id);
            chk("vec_busy",  busy,      1'b0);
            idle(2);
        end

        // Bad character then idle garbage
        send_byte(8'h02); send_byte("0"); send_byte("G");
        chk("badchar_err",  tag_err,  1'b1);
        chk("badchar_code", err_code, 2'd0);
        repeat (3) send_byte(8'h41);
        idle(2);

        // Resync on a second STX, then a good frame
        send_byte(8'h02); send_str("123");
        send_byte(8'h02);
        chk("resync_err",  tag_err,  1'b1);
        chk("resync_code", err_code, 2'd3);
        chk("resync_busy", busy,     1'b1);
        send_str("0B1B2C3D4E4F");
        send_byte(8'h03);
        chk("resync_valid", tag_valid, 1'b1);
        chk("resync_id",    tag_id,    40'h0B1B2C3D4E);
        idle(1);

        // Timeout, and a byte landing on the expiry edge
        send_byte(8'h02); send_byte("0");
        expect_timeout("timeout");
        send_byte(8'h02); send_byte("0");
        repeat (TO - 2) @(negedge clk);
        send_byte("1");
        chk("late_byte_err",  tag_err, 1'b0);
        chk("late_byte_busy", busy,    1'b1);
        expect_timeout("timeout2");

        // Reset mid-frame
        send_byte(8'h02); send_str("ABCDEF");
        rst_n = 1'b0;
        #1;
        chk("midrst_id",    tag_id,    40'd0);
        chk("midrst_busy",  busy,      1'b0);
        chk("midrst_err",   tag_err,   1'b0);
        chk("midrst_valid", tag_valid, 1'b0);
        chk("midrst_code",  err_code,  2'd0);
        mact = 1'b0; m_id = 40'd0; m_code = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h02); send_str("0A1B2C3D4E4e"); send_byte(8'h03);
        chk("postrst_id", tag_id, 40'h0A1B2C3D4E);

        // Random frames with assorted corruptions
        for (int f = 0; f < 40; f++) begin
            logic [7:0]  q[$];
            logic [39:0] id;
            logic [7:0]  cs;
            int          kind;
            id = {8'($urandom), 32'($urandom)};
            cs = 8'd0;
            for (int k = 0; k < 5; k++) cs ^= id[39-8*k -: 8];
            kind = $urandom_range(0, 4);
            if (kind == 1) cs ^= 8'($urandom_range(1, 255));
            q.push_back(8'h02);
            for (int i = 0; i < 10; i++) q.push_back(hexc(id[39-4*i -: 4], bit'($urandom_range(0, 1))));
            q.push_back(hexc(cs[7:4], bit'($urandom_range(0, 1))));
            q.push_back(hexc(cs[3:0], bit'($urandom_range(0, 1))));
            q.push_back(8'h03);
            if (kind == 2) q[$urandom_range(1, 12)] = ($urandom_range(0, 1) != 0) ? 8'h47 : 8'h20;
            if (kind == 3) q[$urandom_range(1, 13)] = 8'h02;
            if (kind == 4) q[13] = 8'($urandom_range(4, 255));
            foreach (q[i]) begin
                send_byte(q[i]);
                idle($urandom_range(0, 2));
            end
            if ($urandom_range(0, 3) == 0) send_byte(8'h41);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rfid_frame_parser.md
# rfid_frame_parser

Byte-stream parser sitting directly downstream of the 8N1 UART receiver. It consumes the receiver's `rx_data`/`rx_ready` byte strobe and assembles the RFID reader's 14-byte ASCII frame: STX (0x02), 10 hex chars (5-byte tag ID), 2 hex chars (XOR checksum), ETX (0x03). It emits a validated 40-bit tag ID with a one-cycle strobe. Malformed, corrupted or stalled frames produce a one-cycle error strobe with a cause code.

## Interface
- `TIMEOUT_CYCLES`, 156250: max clk cycles between bytes inside a frame (3 byte-times at 9600 baud / 50 MHz); must be ≥ 2.
- `clk`  in  1  system clock, shared with UART receiver
- `rst_n`  in  1  asynchronous, active-low reset
- `rx_data`  in  8  received byte; valid only when `rx_ready`=1
- `rx_ready`  in  1  one-cycle byte strobe
- `tag_id`  out  40  last valid tag ID, MSB = first hex char; holds between frames
- `tag_valid`  out  1  one-cycle pulse: `tag_id` just updated
- `tag_err`  out  1  one-cycle pulse: frame discarded
- `err_code`  out  2  cause, valid with `tag_err`, held until next error: 0 bad char, 1 checksum, 2 timeout, 3 resync
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, DATA, CSUM, ETX.
- IDLE: on `rx_ready` with 0x02, clear char counter, ID shift register, running XOR and timeout counter, then go to DATA. All other bytes are ignored silently.
- Hex decode: '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66) map to nibble 0-F.
- DATA: each hex char shifts its nibble into the 40-bit register (left shift by 4).
  - After every 2nd char, XOR the completed byte into the running checksum.
  - After the 10th char, go to CSUM.
- CSUM: collect 2 hex chars into the 8-bit received checksum. After the 2nd char, go to ETX.
- ETX: on 0x03, compare the received checksum to the running XOR.
  - Match: load `tag_id`, pulse `tag_valid`.
  - Mismatch: pulse `tag_err`, code 1.
  - Either way, return to IDLE.
- Error rules in DATA/CSUM/ETX:
  - Non-hex char in DATA/CSUM, or any byte other than 0x03/0x02 in ETX: `tag_err` code 0, go to IDLE.
  - 0x02 received: `tag_err` code 3, then restart the frame exactly as from IDLE (go to DATA, state cleared). The 0x02 byte is not lost.
- Timeout: counter clears on every `rx_ready` and increments each cycle while not IDLE. When it reaches `TIMEOUT_CYCLES`-1 with no `rx_ready` that cycle: `tag_err` code 2, go to IDLE.
- Simultaneous `rx_ready` and timeout expiry: the byte wins; it is processed normally and the counter clears.
- `tag_id` changes only on a valid frame; errors never modify it.

## Timing
- Reset values: `tag_id`=0, `tag_valid`=0, `tag_err`=0, `err_code`=0, `busy`=0, state IDLE, internal counters 0.
- Reset asserted mid-frame aborts immediately with no strobe; the next frame must start with a fresh 0x02.
- All outputs are registered.
- `rx_ready` sampled high at edge N produces `tag_valid`/`tag_err`/state change visible after edge N (cycle N+1). Latency from ETX strobe is 1 cycle.
- `tag_valid` and `tag_err` are never high in the same cycle; each is exactly 1 cycle wide.
- `busy` rises the cycle after STX is accepted and falls the cycle `tag_valid`/`tag_err` is asserted (except resync, where it stays high).
- No backpressure: a byte is accepted every cycle `rx_ready` is high, including back-to-back strobes.
- Timeout counter width: ceil(log2(`TIMEOUT_CYCLES`)).

## Test plan
- **Good frame:** 02 '0''A''1''B''2''C''3''D''4''E''4''E' 03 → `tag_valid` pulse 1 cycle after ETX strobe, `tag_id`=0x0A1B2C3D4E, `busy` low afterward.
- **Lowercase frame:** same frame with checksum "4e" → identical result. Then a frame with checksum '4''F' → `tag_err`, `err_code`=1, `tag_id` still 0x0A1B2C3D4E.
- **Bad char:** 02 '0''G' → `tag_err` code 0 on the 'G' strobe +1. Subsequent garbage bytes 0x41 in IDLE → no strobes.
- **Resync:** 02 '1''2''3' 02 followed by a full good frame → `tag_err` code 3 at the second STX, then `tag_valid` with the new ID.
- **Timeout:** with `TIMEOUT_CYCLES`=100, send 02 '0', then idle → `tag_err` code 2 exactly 99 cycles after the last strobe. A byte arriving on cycle 99 is accepted instead, with no error.
- **Reset mid-frame:** assert `rst_n` low after 6 chars → all outputs 0 immediately. Post-reset good frame decodes correctly.
